// File: rtl/sr_ff_bank.sv
// N-channel SR/JK/D/T flip-flop bank with illegal-input logging (sticky flag + saturating counter).
// Define SR_FF_BANK_EDGE_DET_EN to add registered rise/fall pulse outputs.
module sr_ff_bank #(
   parameter int             N           = 8,
   parameter logic [N-1:0]   RST_VAL     = {N{1'b0}},
   parameter int             SR_PRIORITY = 0,
   parameter int             CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             clr_err,
   output logic [N-1:0]     q,
   output logic [N-1:0]     qbar,
   output logic [N-1:0]     illegal,
   output logic             err_sticky,
`ifdef SR_FF_BANK_EDGE_DET_EN
   output logic [CNT_W-1:0] err_cnt,
   output logic [N-1:0]     rise,
   output logic [N-1:0]     fall
`else
   output logic [CNT_W-1:0] err_cnt
`endif
);

   typedef enum logic [1:0] {
      MODE_SR = 2'b00,
      MODE_JK = 2'b01,
      MODE_D  = 2'b10,
      MODE_T  = 2'b11
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   mode_e            mode_w;
   logic [N-1:0]     q_q, q_d;
   logic [N-1:0]     illegal_q, illegal_d;
   logic [N-1:0]     sr_ill_w;
   logic             event_w;
   logic             err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d, err_cnt_base;

   assign mode_w   = mode_e'(mode);
   assign sr_ill_w = (mode_w == MODE_SR) ? (a & b) : '0;
   assign event_w  = en & (|sr_ill_w);

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      q_d       = q_q;
      illegal_d = illegal_q;
      if (en) begin
         illegal_d = sr_ill_w;
         for (int i = 0; i < N; i++) begin
            unique case (mode_w)
               MODE_SR: begin
                  case ({a[i], b[i]})
                     2'b01: q_d[i] = 1'b0;
                     2'b10: q_d[i] = 1'b1;
                     2'b11: begin
                        if (SR_PRIORITY == 1)      q_d[i] = 1'b1;
                        else if (SR_PRIORITY == 2) q_d[i] = 1'b0;
                     end
                     default: q_d[i] = q_q[i];
                  endcase
               end
               MODE_JK: begin
                  case ({a[i], b[i]})
                     2'b01:   q_d[i] = 1'b0;
                     2'b10:   q_d[i] = 1'b1;
                     2'b11:   q_d[i] = ~q_q[i];
                     default: q_d[i] = q_q[i];
                  endcase
               end
               MODE_D:  q_d[i] = a[i];
               MODE_T:  q_d[i] = q_q[i] ^ a[i];
            endcase
         end
      end
   end

   // Clear happens first, so a same-edge event counts from zero.
   always_comb begin
      err_cnt_base = clr_err ? '0 : err_cnt_q;
      err_cnt_d    = err_cnt_base;
      if (event_w && (err_cnt_base != CNT_MAX)) err_cnt_d = err_cnt_base + CNT_W'(1);
      err_sticky_d = (err_sticky_q & ~clr_err) | event_w;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_q          <= RST_VAL;
         illegal_q    <= '0;
         err_sticky_q <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         q_q          <= q_d;
         illegal_q    <= illegal_d;
         err_sticky_q <= err_sticky_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

`ifdef SR_FF_BANK_EDGE_DET_EN
   logic [N-1:0] rise_q, fall_q;

   // Reset holds the pulses low, so loading RST_VAL never shows up as an edge.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= q_d & ~q_q;
         fall_q <= ~q_d & q_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`endif

   assign q          = q_q;
   assign qbar       = ~q_q;
   assign illegal    = illegal_q;
   assign err_sticky = err_sticky_q;
   assign err_cnt    = err_cnt_q;

endmodule
